booth_r4_seq_mult: RTL

Sequential radix-4 (modified Booth) multiplier, parametrised in operand width, with a per-operation signed/unsigned mode and a start/busy/done handshake. It retires two multiplier bits per clock, so it needs about half the iterations of the radix-2 right-shift multiplier. It is the standard multi-cycle multiplier for datapaths in the arithmetic library that can tolerate latency but need both signed and unsigned products.

---
 rtl/booth_r4_seq_mult_if.sv | 31 +++
 rtl/booth_r4_seq_mult.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult_if.sv
// ============================================================================
// Module      : booth_r4_seq_mult_if
// Description : Start/busy/done handshake bundle for the radix-4 Booth
//               sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface booth_r4_seq_mult_if #(
    parameter int N = 32
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic [N-1:0]   x;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    modport master (
        output start, signed_mode, a, x,
        input  busy, done, p
    );

    modport slave (
        input  start, signed_mode, a, x,
        output busy, done, p
    );
endinterface

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
// ============================================================================
// Module      : booth_r4_seq_mult
// Description : Sequential radix-4 (modified Booth) multiplier, signed or
//               unsigned per operation, two multiplier bits retired per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_seq_mult #(
    parameter int N = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    booth_r4_seq_mult_if.slave bus
);

    localparam int L  = N / 2 + 1;
    localparam int CW = $clog2(L);
    localparam int EW = N + 2;
    localparam int AW = N + 3;
    localparam logic [CW-1:0] C_LAST = CW'(L - 1);

    generate
        if ((N % 2) != 0 || N < 4) begin : g_bad_width
            $error("booth_r4_seq_mult: N must be even and at least 4");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_acc;
    logic [EW-1:0]  r_mq;
    logic           r_xlsb;
    logic [EW-1:0]  r_aext;
    logic [2*N-1:0] r_p;
    logic           r_done;

    logic           w_busy;
    logic           w_accept;
    logic           w_last;
    logic [EW-1:0]  w_a_ext;
    logic [EW-1:0]  w_x_ext;
    logic [2:0]     w_trip;
    logic           w_zero;
    logic           w_two;
    logic           w_neg;
    logic [AW-1:0]  w_mag;
    logic [AW-1:0]  w_opnd;
    logic [AW-1:0]  w_sum;
    logic [AW-1:0]  w_acc_sh;
    logic [EW-1:0]  w_mq_sh;
    logic [2*N-1:0] w_prod;

    assign w_busy   = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = w_busy && (r_cnt == C_LAST);

    // Two extra bits let unsigned operands be treated as non-negative signed values.
    assign w_a_ext = bus.signed_mode ? {{2{bus.a[N-1]}}, bus.a} : {2'b00, bus.a};
    assign w_x_ext = bus.signed_mode ? {{2{bus.x[N-1]}}, bus.x} : {2'b00, bus.x};

    assign w_trip = {r_mq[1:0], r_xlsb};

    always_comb begin
        w_zero = 1'b0;
        w_two  = 1'b0;
        w_neg  = 1'b0;
        case (w_trip)
            3'b000, 3'b111: w_zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         w_two  = 1'b1;
            3'b100: begin
                w_two = 1'b1;
                w_neg = 1'b1;
            end
            default:        w_neg  = 1'b1;
        endcase
    end

    always_comb begin
        w_mag = {r_aext[EW-1], r_aext};
        if (w_zero) begin
            w_mag = '0;
        end else if (w_two) begin
            w_mag = {r_aext, 1'b0};
        end
    end

    // Subtraction as inverted operand plus carry-in.
    assign w_opnd   = w_neg ? ~w_mag : w_mag;
    assign w_sum    = r_acc + w_opnd + {{(AW-1){1'b0}}, w_neg};
    assign w_acc_sh = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_mq_sh  = {w_sum[1:0], r_mq[EW-1:2]};
    assign w_prod   = {w_acc_sh[N-3:0], w_mq_sh};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == C_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_mq   <= '0;
            r_xlsb <= 1'b0;
            r_aext <= '0;
            r_p    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_aext <= w_a_ext;
                r_mq   <= w_x_ext;
                r_xlsb <= 1'b0;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else if (w_busy) begin
                r_acc  <= w_acc_sh;
                r_mq   <= w_mq_sh;
                r_xlsb <= r_mq[1];
                r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
                if (w_last) begin
                    r_p <= w_prod;
                end
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.p    = r_p;

endmodule

`default_nettype wire
